// File: rtl/time_pkg.sv
// Shared constants, BCD types and the hour-advance helper for the wall-clock blocks.
package time_pkg;

  typedef logic [3:0] bcd_t;

  typedef struct packed {
    bcd_t tens;
    bcd_t ones;
  } hr_t;

  localparam bcd_t DIGIT_MAX    = 4'd9;
  localparam bcd_t SEC_TENS_MAX = 4'd5;
  localparam bcd_t MIN_TENS_MAX = 4'd5;

  localparam int HR24_MAX = 23;
  localparam int HR12_MAX = 12;
  localparam int HR12_MIN = 1;

  localparam bcd_t RST_DIGIT = 4'd0;
  localparam hr_t  RST_HR24  = '{tens: 4'd0, ones: 4'd0};
  localparam hr_t  RST_HR12  = '{tens: 4'd1, ones: 4'd2};

  function automatic int hr_val(hr_t h);
    return int'(h.tens) * 10 + int'(h.ones);
  endfunction

  function automatic hr_t to_hr(int v);
    hr_t h;
    h.tens = bcd_t'(v / 10);
    h.ones = bcd_t'(v % 10);
    return h;
  endfunction

  // One-hour advance with the format's wrap; the pm flip is handled by the caller.
  function automatic hr_t hr_next(hr_t h, logic mode_24h);
    hr_t n;
    if (mode_24h && hr_val(h) >= HR24_MAX) begin
      n = to_hr(0);
    end else if (!mode_24h && hr_val(h) >= HR12_MAX) begin
      n = to_hr(HR12_MIN);
    end else if (h.ones == DIGIT_MAX) begin
      n.tens = h.tens + 4'd1;
      n.ones = 4'd0;
    end else begin
      n.tens = h.tens;
      n.ones = h.ones + 4'd1;
    end
    return n;
  endfunction

endpackage

// File: rtl/edge_sync.sv
// Resynchronises an asynchronous level and emits a registered one-cycle pulse per rising edge.
// Latency: input rise sampled at edge N gives the pulse after edge N+STAGES; no backpressure.
module edge_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise
);

  localparam int N = (STAGES < 2) ? 2 : STAGES;

  logic [N-1:0] sync_q;
  logic         edge_q;

  // edge_q clears on reset, so a level already high at release counts as one edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
      edge_q <= 1'b0;
      rise   <= 1'b0;
    end else begin
      sync_q <= {sync_q[N-2:0], din};
      edge_q <= sync_q[N-1];
      rise   <= sync_q[N-1] & ~edge_q;
    end
  end

endmodule

// File: rtl/time_keeper.sv
// HH:MM:SS BCD wall clock driven by a 1 Hz tick, with a set mode for minutes and hours.
// Latency: tick_in rise sampled at edge N shows after edge N+SYNC_STAGES+1; no backpressure.
module time_keeper
  import time_pkg::*;
#(
  parameter int MODE_24H    = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_in,
  input  logic       set_en,
  input  logic       inc_min,
  input  logic       inc_hr,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [3:0] min_tens,
  output logic [3:0] hr_ones,
  output logic [3:0] hr_tens,
  output logic       pm,
  output logic       sec_pulse,
  output logic       day_pulse
);

  localparam logic IS_24H = (MODE_24H != 0);
  localparam hr_t  RST_HR = IS_24H ? RST_HR24 : RST_HR12;

  logic tick_rise;
  logic set_q;
  logic set_start;
  logic count_en;
  logic sec_at_max;
  logic min_at_max;
  logic min_step;
  logic hr_step;

  bcd_t sec_ones_q, sec_tens_q, min_ones_q, min_tens_q;
  bcd_t sec_ones_d, sec_tens_d, min_ones_d, min_tens_d;
  hr_t  hr_q, hr_d;
  logic pm_q, pm_d;
  logic sec_pulse_q, sec_pulse_d;
  logic day_pulse_q, day_pulse_d;

  edge_sync #(
    .STAGES(SYNC_STAGES)
  ) u_tick_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (tick_in),
    .rise (tick_rise)
  );

  assign set_start  = set_en & ~set_q;
  // The cycle set_en falls still counts as set mode, so a tick seen there is dropped.
  assign count_en   = tick_rise & ~set_en & ~set_q;
  assign sec_at_max = (sec_ones_q == DIGIT_MAX) && (sec_tens_q == SEC_TENS_MAX);
  assign min_at_max = (min_ones_q == DIGIT_MAX) && (min_tens_q == MIN_TENS_MAX);
  assign min_step   = set_en ? inc_min : (count_en & sec_at_max);
  assign hr_step    = set_en ? inc_hr : (count_en & sec_at_max & min_at_max);

  always_comb begin
    sec_ones_d  = sec_ones_q;
    sec_tens_d  = sec_tens_q;
    min_ones_d  = min_ones_q;
    min_tens_d  = min_tens_q;
    hr_d        = hr_q;
    pm_d        = pm_q;
    sec_pulse_d = 1'b0;
    day_pulse_d = 1'b0;

    if (set_start) begin
      sec_ones_d = RST_DIGIT;
      sec_tens_d = RST_DIGIT;
    end else if (count_en) begin
      sec_pulse_d = 1'b1;
      if (sec_ones_q == DIGIT_MAX) begin
        sec_ones_d = RST_DIGIT;
        sec_tens_d = (sec_tens_q == SEC_TENS_MAX) ? RST_DIGIT : sec_tens_q + 4'd1;
      end else begin
        sec_ones_d = sec_ones_q + 4'd1;
      end
    end

    if (min_step) begin
      if (min_ones_q == DIGIT_MAX) begin
        min_ones_d = RST_DIGIT;
        min_tens_d = (min_tens_q == MIN_TENS_MAX) ? RST_DIGIT : min_tens_q + 4'd1;
      end else begin
        min_ones_d = min_ones_q + 4'd1;
      end
    end

    // 12 h: 11 -> 12 flips AM/PM; PM 11 -> AM 12 is the day boundary.
    if (hr_step) begin
      hr_d = hr_next(hr_q, IS_24H);
      if (!IS_24H && hr_val(hr_q) == HR12_MAX - 1) begin
        pm_d = ~pm_q;
      end
      day_pulse_d = count_en & (IS_24H ? (hr_val(hr_q) == HR24_MAX)
                                       : ((hr_val(hr_q) == HR12_MAX - 1) && pm_q));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sec_ones_q  <= RST_DIGIT;
      sec_tens_q  <= RST_DIGIT;
      min_ones_q  <= RST_DIGIT;
      min_tens_q  <= RST_DIGIT;
      hr_q        <= RST_HR;
      pm_q        <= 1'b0;
      set_q       <= 1'b0;
      sec_pulse_q <= 1'b0;
      day_pulse_q <= 1'b0;
    end else begin
      sec_ones_q  <= sec_ones_d;
      sec_tens_q  <= sec_tens_d;
      min_ones_q  <= min_ones_d;
      min_tens_q  <= min_tens_d;
      hr_q        <= hr_d;
      pm_q        <= pm_d;
      set_q       <= set_en;
      sec_pulse_q <= sec_pulse_d;
      day_pulse_q <= day_pulse_d;
    end
  end

  assign sec_ones  = sec_ones_q;
  assign sec_tens  = sec_tens_q;
  assign min_ones  = min_ones_q;
  assign min_tens  = min_tens_q;
  assign hr_ones   = hr_q.ones;
  assign hr_tens   = hr_q.tens;
  assign pm        = IS_24H ? 1'b0 : pm_q;
  assign sec_pulse = sec_pulse_q;
  assign day_pulse = day_pulse_q;

endmodule

// File: tb/tb_time_keeper.sv
// Drives a 24 h and a 12 h time_keeper with shared stimulus and scores both against a seconds-of-day model.
module tb_time_keeper;

  logic clk = 1'b0;
  logic rst_n, tick_in, set_en, inc_min, inc_hr;

  logic [3:0] a_so, a_st, a_mo, a_mt, a_ho, a_ht;
  logic       a_pm, a_sp, a_dp;
  logic [3:0] b_so, b_st, b_mo, b_mt, b_ho, b_ht;
  logic       b_pm, b_sp, b_dp;

  always #5 clk = ~clk;

  time_keeper #(.MODE_24H(1), .SYNC_STAGES(2)) dut24 (
    .clk(clk), .rst_n(rst_n), .tick_in(tick_in), .set_en(set_en),
    .inc_min(inc_min), .inc_hr(inc_hr),
    .sec_ones(a_so), .sec_tens(a_st), .min_ones(a_mo), .min_tens(a_mt),
    .hr_ones(a_ho), .hr_tens(a_ht), .pm(a_pm), .sec_pulse(a_sp), .day_pulse(a_dp)
  );

  time_keeper #(.MODE_24H(0), .SYNC_STAGES(2)) dut12 (
    .clk(clk), .rst_n(rst_n), .tick_in(tick_in), .set_en(set_en),
    .inc_min(inc_min), .inc_hr(inc_hr),
    .sec_ones(b_so), .sec_tens(b_st), .min_ones(b_mo), .min_tens(b_mt),
    .hr_ones(b_ho), .hr_tens(b_ht), .pm(b_pm), .sec_pulse(b_sp), .day_pulse(b_dp)
  );

  typedef struct {
    int t;
    bit day;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   model_t  = 0;   // seconds since midnight
  bit   in_set   = 1'b0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [23:0] bcd6(int h, int m, int s);
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  function automatic bit legal(logic [3:0] ht, logic [3:0] ho, logic [3:0] mt,
                               logic [3:0] mo, logic [3:0] st, logic [3:0] so, bit is24);
    int hv;
    if ($isunknown({ht, ho, mt, mo, st, so})) return 1'b0;
    hv = int'(ht) * 10 + int'(ho);
    return (so <= 9) && (st <= 5) && (mo <= 9) && (mt <= 5) && (ho <= 9) &&
           (is24 ? (hv <= 23) : (hv >= 1 && hv <= 12));
  endfunction

  task automatic compare_time(string tag, int tt);
    int h, m, s, h12;
    h   = tt / 3600;
    m   = (tt / 60) % 60;
    s   = tt % 60;
    h12 = (h % 12 == 0) ? 12 : h % 12;
    chk({tag, "_hms24"}, {8'h0, a_ht, a_ho, a_mt, a_mo, a_st, a_so}, {8'h0, bcd6(h, m, s)});
    chk({tag, "_hms12"}, {8'h0, b_ht, b_ho, b_mt, b_mo, b_st, b_so}, {8'h0, bcd6(h12, m, s)});
    chk({tag, "_pm12"}, {31'd0, b_pm}, 32'(h >= 12));
    chk({tag, "_pm24"}, {31'd0, a_pm}, 32'd0);
  endtask

  // Monitor: every sec_pulse consumes one expected second from the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1) begin
      chk("bcd_legal24", {31'd0, legal(a_ht, a_ho, a_mt, a_mo, a_st, a_so, 1'b1)}, 32'd1);
      chk("bcd_legal12", {31'd0, legal(b_ht, b_ho, b_mt, b_mo, b_st, b_so, 1'b0)}, 32'd1);
      if (a_sp !== 1'b0 || b_sp !== 1'b0) begin
        chk("sec_pulse_pair", {31'd0, b_sp}, {31'd0, a_sp});
        if (exp_q.size() == 0) begin
          chk("unexpected_sec_pulse", {31'd0, a_sp}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          compare_time("tick", e.t);
          chk("day_pulse24", {31'd0, a_dp}, {31'd0, e.day});
          chk("day_pulse12", {31'd0, b_dp}, {31'd0, e.day});
        end
      end else begin
        chk("day_pulse_quiet", {30'd0, a_dp, b_dp}, 32'd0);
      end
    end
  end

  task automatic push_tick();
    exp_t e;
    e.day   = (model_t == 86399);
    model_t = (model_t + 1) % 86400;
    e.t     = model_t;
    exp_q.push_back(e);
  endtask

  task automatic send_tick(int hi, int lo);
    @(negedge clk);
    tick_in = 1'b1;
    if (!in_set) push_tick();
    repeat (hi) @(negedge clk);
    tick_in = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic enter_set();
    @(negedge clk);
    set_en  = 1'b1;
    in_set  = 1'b1;
    model_t = model_t - (model_t % 60);
    repeat (3) @(negedge clk);
  endtask

  task automatic exit_set();
    @(negedge clk);
    set_en = 1'b0;
    in_set = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic pulse_inc(bit do_min, bit do_hr);
    int h, m, s;
    @(negedge clk);
    inc_min = do_min;
    inc_hr  = do_hr;
    if (in_set) begin
      h = model_t / 3600;
      m = (model_t / 60) % 60;
      s = model_t % 60;
      if (do_min) m = (m + 1) % 60;
      if (do_hr)  h = (h + 1) % 24;
      model_t = h * 3600 + m * 60 + s;
    end
    @(negedge clk);
    inc_min = 1'b0;
    inc_hr  = 1'b0;
  endtask

  task automatic goto_time(int h, int m, int s);
    enter_set();
    while (model_t / 3600 != h) pulse_inc(1'b0, 1'b1);
    while ((model_t / 60) % 60 != m) pulse_inc(1'b1, 1'b0);
    exit_set();
    repeat (s) send_tick(1, 4);
  endtask

  task automatic wait_drain(string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_drain"}, exp_q.size(), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_time(string tag);
    wait_drain(tag);
    compare_time(tag, model_t);
  endtask

  initial begin
    #800000;
    failures++;
    $display("FAIL global_timeout actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  initial begin
    rst_n   = 1'b0;
    tick_in = 1'b0;
    set_en  = 1'b0;
    inc_min = 1'b0;
    inc_hr  = 1'b0;
    repeat (3) @(negedge clk);
    compare_time("reset_hold", 0);
    chk("reset_sec_pulse", {30'd0, a_sp, b_sp}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    compare_time("post_reset", 0);

    // Tick rises before edge N; pulse and new digit appear after edge N+3 only.
    tick_in = 1'b1;
    push_tick();
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk($sformatf("latency_k%0d", k), {31'd0, a_sp}, 32'(k == 4));
      if (k == 4) chk("latency_sec_ones", {28'd0, a_so}, 32'd1);
    end
    tick_in = 1'b0;
    repeat (4) @(negedge clk);
    check_time("latency_done");

    goto_time(23, 59, 58);
    check_time("preload_235958");
    send_tick(2, 5);
    check_time("t235959");
    send_tick(1, 4);
    check_time("midnight");

    goto_time(11, 59, 59);
    send_tick(1, 4);
    check_time("noon");
    goto_time(12, 59, 59);
    send_tick(3, 4);
    check_time("one_pm");
    goto_time(23, 59, 59);
    send_tick(1, 4);
    check_time("pm_to_am_midnight");

    goto_time(10, 20, 37);
    check_time("t102037");
    enter_set();
    check_time("set_clear_sec");
    repeat (45) pulse_inc(1'b1, 1'b0);
    check_time("set_45_min");
    repeat (3) send_tick($urandom_range(1, 3), 5);
    check_time("set_ticks_ignored");
    pulse_inc(1'b1, 1'b1);
    check_time("set_min_and_hr");
    exit_set();

    repeat (4) pulse_inc(1'(($urandom_range(0, 1))), 1'b1);
    check_time("normal_inc_ignored");
    send_tick(20, 5);
    check_time("long_high_tick");

    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 3))
        0: repeat ($urandom_range(1, 5)) send_tick($urandom_range(1, 4), $urandom_range(4, 7));
        1: begin
          enter_set();
          repeat ($urandom_range(1, 30)) begin
            case ($urandom_range(0, 3))
              0: pulse_inc(1'b1, 1'b0);
              1: pulse_inc(1'b0, 1'b1);
              2: pulse_inc(1'b1, 1'b1);
              default: send_tick($urandom_range(1, 3), 4);
            endcase
          end
          exit_set();
        end
        2: repeat ($urandom_range(1, 4))
             pulse_inc(1'(($urandom_range(0, 1))), 1'(($urandom_range(0, 1))));
        default: begin
          goto_time($urandom_range(0, 23), $urandom_range(0, 59), 58);
          repeat (3) send_tick(1, 4);
        end
      endcase
      check_time($sformatf("rand%0d", i));
    end

    // Reset in the middle of an adjust, with tick_in held high across release.
    enter_set();
    pulse_inc(1'b1, 1'b1);
    @(negedge clk);
    inc_min = 1'b1;
    rst_n   = 1'b0;
    @(negedge clk);
    inc_min = 1'b0;
    set_en  = 1'b0;
    in_set  = 1'b0;
    tick_in = 1'b1;
    model_t = 0;
    exp_q.delete();
    @(negedge clk);
    compare_time("reset_in_set", 0);
    rst_n = 1'b1;
    push_tick();
    repeat (8) @(negedge clk);
    tick_in = 1'b0;
    check_time("held_level_after_reset");
    send_tick(1, 4);
    check_time("count_after_reset");

    wait_drain("final");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
